// File: rtl/relu_maxpool2x2_pkg.sv
// Shared constants and the lane-control bundle for the ReLU + 2x2 max-pool stage.
// The top level may override the map geometry; these are the defaults.
package relu_maxpool2x2_pkg;

  localparam int ACCW   = 32;
  localparam int MAP_W  = 26;
  localparam int MAP_H  = 26;
  localparam int POOL_W = MAP_W / 2;
  localparam int POOL_H = MAP_H / 2;
  localparam int LB_AW  = $clog2(POOL_W);

  typedef struct packed {
    logic accept;
    logic col_odd;
    logic row_odd;
    logic pair_en;
  } lane_ctl_t;

  // Address width that never collapses to zero bits for tiny maps.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/relu_maxpool2x2_lane.sv
// One channel of the pooling datapath: ReLU, horizontal pair hold, half-width
// line buffer for the even row, vertical max and the registered result.
module relu_pool_lane
  import relu_maxpool2x2_pkg::*;
#(
  parameter int ACCW   = 32,
  parameter int POOL_W = 13,
  parameter int LB_AW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic             col_odd,
  input  logic             row_odd,
  input  logic             pair_en,
  input  logic [LB_AW-1:0] addr,
  input  logic [ACCW-1:0]  din,
  output logic [ACCW-1:0]  dout
);

  function automatic logic [ACCW-1:0] smax(input logic [ACCW-1:0] a,
                                           input logic [ACCW-1:0] b);
    return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

  logic [ACCW-1:0] hold_r;
  logic [ACCW-1:0] out_r;
  logic [ACCW-1:0] lbuf_r [POOL_W];
  logic [ACCW-1:0] relu_s;
  logic [ACCW-1:0] pair_s;
  logic [ACCW-1:0] vmax_s;
  logic            take_s;
  logic            lb_wr_s;
  logic            res_wr_s;

  // ReLU, pair max, vertical max and write strobes.
  always_comb begin
    relu_s   = {ACCW{1'b0}};
    if (din[ACCW-1]) begin
      relu_s = {ACCW{1'b0}};
    end else begin
      relu_s = din;
    end
    pair_s   = smax(hold_r, relu_s);
    vmax_s   = smax(lbuf_r[addr], pair_s);
    take_s   = accept & pair_en;
    lb_wr_s  = take_s & col_odd & ~row_odd;
    res_wr_s = take_s & col_odd & row_odd;
  end

  // Hold register for the even column and the registered pooled result.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_r <= {ACCW{1'b0}};
      out_r  <= {ACCW{1'b0}};
    end else begin
      if (take_s && !col_odd) begin
        hold_r <= relu_s;
      end else begin
        hold_r <= hold_r;
      end
      if (res_wr_s) begin
        out_r <= vmax_s;
      end else begin
        out_r <= out_r;
      end
    end
  end

  // Line buffer carries no reset: every slot is written on the even row first.
  always_ff @(posedge clk) begin
    if (lb_wr_s) begin
      lbuf_r[addr] <= pair_s;
    end else begin
      lbuf_r[addr] <= lbuf_r[addr];
    end
  end

  assign dout = out_r;

endmodule

// File: rtl/relu_maxpool2x2.sv
// Streaming ReLU followed by 2x2/stride-2 max pooling on four conv channels.
// Owns the map position counters, beat acceptance and the output strobes.
module relu_maxpool2x2
  import relu_maxpool2x2_pkg::*;
#(
  parameter int ACCW  = relu_maxpool2x2_pkg::ACCW,
  parameter int MAP_W = relu_maxpool2x2_pkg::MAP_W,
  parameter int MAP_H = relu_maxpool2x2_pkg::MAP_H
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic [3:0]      iValid,
  input  logic [ACCW-1:0] iData0,
  input  logic [ACCW-1:0] iData1,
  input  logic [ACCW-1:0] iData2,
  input  logic [ACCW-1:0] iData3,
  output logic            oValid,
  output logic [ACCW-1:0] oData0,
  output logic [ACCW-1:0] oData1,
  output logic [ACCW-1:0] oData2,
  output logic [ACCW-1:0] oData3,
  output logic            oMapDone,
  output logic            oErr
);

  localparam int PW  = MAP_W / 2;
  localparam int LBW = clog2_min1(PW);
  localparam int CW  = clog2_min1(MAP_W);
  localparam int RW  = clog2_min1(MAP_H);
  // With an odd map height the map ends on the ignored last row, so the done
  // pulse follows the final beat instead of the last pooled output.
  localparam int DONE_COL = (MAP_H % 2 == 1) ? (MAP_W - 1) : (2 * PW - 1);

  localparam logic [CW-1:0] COL_LAST   = CW'(MAP_W - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(MAP_H - 1);
  localparam logic [CW-1:0] DONE_COL_C = CW'(DONE_COL);

  logic [CW-1:0]   col_r;
  logic [RW-1:0]   row_r;
  logic            valid_r;
  logic            done_r;
  logic            err_r;
  logic            accept_s;
  logic            partial_s;
  logic            col_wrap_s;
  logic            row_wrap_s;
  logic            col_pair_s;
  logic            row_pair_s;
  logic            out_fire_s;
  logic            done_fire_s;
  logic [LBW-1:0]  addr_s;
  lane_ctl_t       ctl_s;
  logic [ACCW-1:0] din_s  [4];
  logic [ACCW-1:0] dout_s [4];

  // Beat qualification and the control bundle broadcast to all lanes.
  always_comb begin
    accept_s   = (iValid == 4'hF);
    partial_s  = (iValid != 4'h0) && (iValid != 4'hF);
    col_wrap_s = (col_r == COL_LAST);
    row_wrap_s = (row_r == ROW_LAST);
    col_pair_s = 1'b1;
    if ((MAP_W % 2) == 1) begin
      col_pair_s = ~col_wrap_s;
    end else begin
      col_pair_s = 1'b1;
    end
    row_pair_s = 1'b1;
    if ((MAP_H % 2) == 1) begin
      row_pair_s = ~row_wrap_s;
    end else begin
      row_pair_s = 1'b1;
    end
    addr_s        = LBW'(col_r >> 1);
    ctl_s.accept  = accept_s;
    ctl_s.col_odd = col_r[0];
    ctl_s.row_odd = row_r[0];
    ctl_s.pair_en = col_pair_s & row_pair_s;
    out_fire_s    = accept_s & col_r[0] & row_r[0] & col_pair_s & row_pair_s;
    done_fire_s   = accept_s & (col_r == DONE_COL_C) & row_wrap_s;
  end

  // Map position counters advance only on accepted beats.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      col_r <= {CW{1'b0}};
      row_r <= {RW{1'b0}};
    end else if (accept_s) begin
      if (col_wrap_s) begin
        col_r <= {CW{1'b0}};
        if (row_wrap_s) begin
          row_r <= {RW{1'b0}};
        end else begin
          row_r <= row_r + RW'(1);
        end
      end else begin
        col_r <= col_r + CW'(1);
        row_r <= row_r;
      end
    end else begin
      col_r <= col_r;
      row_r <= row_r;
    end
  end

  // Output strobes and the sticky partial-valid flag.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      valid_r <= out_fire_s;
      done_r  <= done_fire_s;
      err_r   <= err_r | partial_s;
    end
  end

  assign din_s[0] = iData0;
  assign din_s[1] = iData1;
  assign din_s[2] = iData2;
  assign din_s[3] = iData3;

  for (genvar ch = 0; ch < 4; ch++) begin : g_lane
    relu_pool_lane #(
      .ACCW   (ACCW),
      .POOL_W (PW),
      .LB_AW  (LBW)
    ) u_lane (
      .clk     (iClk),
      .rst     (iRst),
      .accept  (ctl_s.accept),
      .col_odd (ctl_s.col_odd),
      .row_odd (ctl_s.row_odd),
      .pair_en (ctl_s.pair_en),
      .addr    (addr_s),
      .din     (din_s[ch]),
      .dout    (dout_s[ch])
    );
  end

  assign oValid   = valid_r;
  assign oMapDone = done_r;
  assign oErr     = err_r;
  assign oData0   = dout_s[0];
  assign oData1   = dout_s[1];
  assign oData2   = dout_s[2];
  assign oData3   = dout_s[3];

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Directed bench: a 4x4 instance for hand-computed maps and a default 26x26
// instance streamed with two back-to-back random maps against a direct model.
module tb_relu_maxpool2x2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // small (4x4) instance
  logic        s_rst;
  logic [3:0]  s_valid;
  logic [31:0] s_d0, s_d1, s_d2, s_d3;
  logic        s_ovalid, s_done, s_err;
  logic [31:0] s_o0, s_o1, s_o2, s_o3;

  // large (26x26) instance
  logic        l_rst;
  logic [3:0]  l_valid;
  logic [31:0] l_d0, l_d1, l_d2, l_d3;
  logic        l_ovalid, l_done, l_err;
  logic [31:0] l_o0, l_o1, l_o2, l_o3;

  relu_maxpool2x2 #(.ACCW(32), .MAP_W(4), .MAP_H(4)) u_small (
    .iClk(clk), .iRst(s_rst), .iValid(s_valid),
    .iData0(s_d0), .iData1(s_d1), .iData2(s_d2), .iData3(s_d3),
    .oValid(s_ovalid), .oData0(s_o0), .oData1(s_o1), .oData2(s_o2), .oData3(s_o3),
    .oMapDone(s_done), .oErr(s_err)
  );

  relu_maxpool2x2 u_large (
    .iClk(clk), .iRst(l_rst), .iValid(l_valid),
    .iData0(l_d0), .iData1(l_d1), .iData2(l_d2), .iData3(l_d3),
    .oValid(l_ovalid), .oData0(l_o0), .oData1(l_o1), .oData2(l_o2), .oData3(l_o3),
    .oMapDone(l_done), .oErr(l_err)
  );

  // 4x4 map for channel 0; ch1 = -ch0, ch2 = 2*ch0, ch3 = 0x7FFFFFFF
  int m0 [16] = '{1, -5, 3, 2,  4, 0, -1, 7,  -1, -2, -3, -4,  -9, -8, -7, -6};
  int e0 [4]  = '{4, 7, 0, 0};
  int e1 [4]  = '{5, 1, 9, 7};
  int e2 [4]  = '{8, 14, 0, 0};

  int lm   [2][4][676];
  int lexp [2][4][169];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one beat at a falling edge; on return the DUT has registered it.
  task automatic s_beat(input logic [3:0] v, input int i);
    s_valid = v;
    s_d0 = 32'(m0[i]);
    s_d1 = 32'(-m0[i]);
    s_d2 = 32'(2 * m0[i]);
    s_d3 = 32'h7FFF_FFFF;
    @(negedge clk);
    s_valid = 4'h0;
  endtask

  task automatic run_map(input int gapmax, input int bad_at, input logic exp_err);
    int k;
    int nv;
    int ngap;
    logic is_out;
    k  = 0;
    nv = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == bad_at) begin
        s_beat(4'b0101, i);
        nv += int'(s_ovalid);
        chk("bad_beat_valid", {31'd0, s_ovalid}, 32'd0);
        chk("bad_beat_err", {31'd0, s_err}, 32'd1);
      end
      ngap = int'($urandom_range(gapmax, 0));
      for (int g = 0; g < ngap; g++) begin
        @(negedge clk);
        nv += int'(s_ovalid);
        chk("gap_valid", {31'd0, s_ovalid}, 32'd0);
      end
      s_beat(4'hF, i);
      nv += int'(s_ovalid);
      is_out = ((i % 2) == 1) && (((i / 4) % 2) == 1);
      chk("valid", {31'd0, s_ovalid}, {31'd0, is_out});
      chk("map_done", {31'd0, s_done}, {31'd0, (i == 15)});
      if (is_out) begin
        chk("ch0", s_o0, 32'(e0[k]));
        chk("ch1", s_o1, 32'(e1[k]));
        chk("ch2", s_o2, 32'(e2[k]));
        chk("ch3", s_o3, 32'h7FFF_FFFF);
        k++;
      end
    end
    @(negedge clk);
    nv += int'(s_ovalid);
    chk("hold_data", s_o1, 32'(e1[3]));
    chk("out_count", 32'(nv), 32'd4);
    chk("err", {31'd0, s_err}, {31'd0, exp_err});
  endtask

  initial begin
    int nv;
    int nd;
    int mx;
    int v;
    int idx;
    logic exp_v;
    s_rst = 1'b1; s_valid = 4'h0; s_d0 = 32'd0; s_d1 = 32'd0; s_d2 = 32'd0; s_d3 = 32'd0;
    l_rst = 1'b1; l_valid = 4'h0; l_d0 = 32'd0; l_d1 = 32'd0; l_d2 = 32'd0; l_d3 = 32'd0;
    repeat (2) @(negedge clk);

    chk("rst_valid", {31'd0, s_ovalid}, 32'd0);
    chk("rst_data0", s_o0, 32'd0);
    chk("rst_data3", s_o3, 32'd0);
    chk("rst_done", {31'd0, s_done}, 32'd0);
    chk("rst_err", {31'd0, s_err}, 32'd0);
    chk("rst_l_valid", {31'd0, l_ovalid}, 32'd0);
    chk("rst_l_data2", l_o2, 32'd0);
    s_rst = 1'b0;
    l_rst = 1'b0;

    // basic back-to-back map, then gapped, then a partial-valid beat in row 1
    run_map(0, -1, 1'b0);
    run_map(3, -1, 1'b0);
    run_map(0, 6, 1'b1);

    // reset mid-map after 6 beats, then a fresh map
    for (int i = 0; i < 6; i++) s_beat(4'hF, i);
    s_rst = 1'b1;
    @(negedge clk);
    s_rst = 1'b0;
    chk("midrst_valid", {31'd0, s_ovalid}, 32'd0);
    chk("midrst_err", {31'd0, s_err}, 32'd0);
    chk("midrst_data", s_o0, 32'd0);
    run_map(0, -1, 1'b0);

    // 26x26: two back-to-back random maps against a direct 2x2 window model
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 676; j++) lm[p][c][j] = int'($urandom);
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < 4; c++)
        for (int pr = 0; pr < 13; pr++)
          for (int pc = 0; pc < 13; pc++) begin
            mx = 0;
            for (int dy = 0; dy < 2; dy++)
              for (int dx = 0; dx < 2; dx++) begin
                v = lm[p][c][(2 * pr + dy) * 26 + 2 * pc + dx];
                if (v > mx) mx = v;
              end
            lexp[p][c][pr * 13 + pc] = mx;
          end

    nv = 0;
    nd = 0;
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < 26; r++)
        for (int c = 0; c < 26; c++) begin
          l_valid = 4'hF;
          l_d0 = 32'(lm[p][0][r * 26 + c]);
          l_d1 = 32'(lm[p][1][r * 26 + c]);
          l_d2 = 32'(lm[p][2][r * 26 + c]);
          l_d3 = 32'(lm[p][3][r * 26 + c]);
          @(negedge clk);
          l_valid = 4'h0;
          nv += int'(l_ovalid);
          nd += int'(l_done);
          exp_v = ((r % 2) == 1) && ((c % 2) == 1);
          chk("l_valid", {31'd0, l_ovalid}, {31'd0, exp_v});
          chk("l_done", {31'd0, l_done}, {31'd0, (r == 25) && (c == 25)});
          if (exp_v) begin
            idx = (r / 2) * 13 + c / 2;
            chk("l_ch0", l_o0, 32'(lexp[p][0][idx]));
            chk("l_ch1", l_o1, 32'(lexp[p][1][idx]));
            chk("l_ch2", l_o2, 32'(lexp[p][2][idx]));
            chk("l_ch3", l_o3, 32'(lexp[p][3][idx]));
          end
        end
    @(negedge clk);
    nv += int'(l_ovalid);
    nd += int'(l_done);
    chk("l_out_count", 32'(nv), 32'd338);
    chk("l_done_count", 32'(nd), 32'd2);
    chk("l_err", {31'd0, l_err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
